// File: rtl/count_sampler.sv
// Samples an upstream 4-bit counter into a small FIFO and tracks its 15->0 wraps.
// Optional sequence checker enabled by defining COUNT_SAMPLER_SEQCHK_EN.
module count_sampler #(
  parameter int DEPTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                count_in,
  input  logic                      sample_en,
  output logic [3:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic                      wrap_pulse,
  output logic [WRAP_W-1:0]         wrap_cnt,
  output logic                      seq_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } trk_state_e;

  // ---------------------------------------------------------------------------
  // Tracker: remembers the previous count and detects the 15->0 wrap.
  // ---------------------------------------------------------------------------
  trk_state_e        state_q, state_d;
  logic [3:0]        prev_q, prev_d;
  logic              wrap_det;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    wrap_det     = 1'b0;
    wrap_pulse_d = 1'b0;
    wrap_cnt_d   = wrap_cnt_q;

    if (state_q == IDLE) begin
      state_d = TRACK;
      prev_d  = count_in;
    end else begin
      prev_d   = count_in;
      wrap_det = (prev_q == 4'hF) && (count_in == 4'h0);
    end

    wrap_pulse_d = wrap_det;
    if (wrap_det && (wrap_cnt_q != {WRAP_W{1'b1}})) begin
      wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      prev_q       <= 4'h0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_cnt_q   <= wrap_cnt_d;
    end
  end

  assign wrap_pulse = wrap_pulse_q;
  assign wrap_cnt   = wrap_cnt_q;

  // ---------------------------------------------------------------------------
  // FIFO: pointers wrap naturally because DEPTH is a power of two.
  // ---------------------------------------------------------------------------
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          full;
  logic          push;
  logic          pop;

  always_comb begin
    full       = (level_q == FULL_LVL);
    pop        = (level_q != '0) && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push       = sample_en && (!full || pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (sample_en && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible
  // because out_data is gated to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= count_in;
    end
  end

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr_q] : 4'h0;
  assign level     = level_q;
  assign overflow  = overflow_q;

  // ---------------------------------------------------------------------------
  // Sequence checker: count_in may only hold or step by one (mod 16).
  // ---------------------------------------------------------------------------
`ifdef COUNT_SAMPLER_SEQCHK_EN
  logic       seq_err_q, seq_err_d;
  logic [3:0] prev_inc;

  always_comb begin
    prev_inc  = prev_q + 4'd1;
    seq_err_d = seq_err_q;
    if ((state_q == TRACK) && (count_in != prev_q) && (count_in != prev_inc)) begin
      seq_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

  a_level_bound : assert property (@(posedge clk) disable iff (reset) level_q <= FULL_LVL);

endmodule

// File: tb/tb_count_sampler.sv
// Self-checking bench for count_sampler: directed stimulus, scoreboard queue,
// and a negedge monitor comparing every output against the bench's own model.
module tb_count_sampler;

  localparam int DEPTH  = 4;
  localparam int WRAP_W = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [3:0]             count_in;
  logic                   sample_en;
  logic [3:0]             out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
  logic                   wrap_pulse;
  logic [WRAP_W-1:0]      wrap_cnt;
  logic                   seq_err;

  always #5 clk = ~clk;

  count_sampler #(.DEPTH(DEPTH), .WRAP_W(WRAP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .sample_en  (sample_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .overflow   (overflow),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt),
    .seq_err    (seq_err)
  );

  int total = 0;
  int bad   = 0;

  logic [3:0]        exp_q[$];
  logic              exp_ovf;
  logic              exp_wp;
  logic              exp_seq;
  logic [WRAP_W-1:0] exp_wc;
  logic              tracking;
  logic [3:0]        last_c;
  logic [3:0]        cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ovf  = 1'b0;
    exp_wp   = 1'b0;
    exp_seq  = 1'b0;
    exp_wc   = '0;
    tracking = 1'b0;
    last_c   = 4'h0;
  endtask

  // Drive one cycle of inputs, predict the DUT's reaction, and commit the
  // prediction at the clock edge that applies it.
  task automatic drive(input logic [3:0] c, input logic se, input logic rdy);
    logic pop;
    logic acc;
    logic det;
    count_in  = c;
    sample_en = se;
    out_ready = rdy;
    pop = (exp_q.size() != 0) && rdy;
    acc = se && ((exp_q.size() < DEPTH) || pop);
    det = tracking && (last_c == 4'hF) && (c == 4'h0);
    @(posedge clk);
    if (acc) exp_q.push_back(c);
    if (se && !acc) exp_ovf = 1'b1;
    exp_wp = det;
    if (det && (exp_wc != {WRAP_W{1'b1}})) exp_wc = exp_wc + 1'b1;
`ifdef COUNT_SAMPLER_SEQCHK_EN
    if (tracking && (c != last_c) && (c != 4'(last_c + 4'd1))) exp_seq = 1'b1;
`endif
    tracking = 1'b1;
    last_c   = c;
    #1;
  endtask

  task automatic tick(input logic se, input logic rdy);
    drive(cnt, se, rdy);
    cnt = cnt + 4'd1;
  endtask

  // Monitor: samples on the falling edge, between driver updates.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("level", level, exp_q.size());
      check("out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && exp_q.size() != 0) begin
        check("out_data", out_data, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end else if (!out_valid) begin
        check("out_data_empty", out_data, 0);
      end
      check("overflow", overflow, exp_ovf);
      check("wrap_pulse", wrap_pulse, exp_wp);
      check("wrap_cnt", wrap_cnt, exp_wc);
      check("seq_err", seq_err, exp_seq);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    cnt       = 4'h0;
    count_in  = 4'h0;
    sample_en = 1'b0;
    out_ready = 1'b0;
    model_reset();

    // Reset state
    #10;
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_out_data", out_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_wrap_pulse", wrap_pulse, 0);
    check("rst_wrap_cnt", wrap_cnt, 0);
    check("rst_seq_err", seq_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Free-running counter, always sampling and always draining; two wraps
    for (int i = 0; i < 34; i++) begin
      tick(1'b1, 1'b1);
      check("stream_level_le1", level <= 1, 1);
    end
    check("stream_wrap_cnt", wrap_cnt, 2);
    check("stream_overflow", overflow, 0);

    // Fill with downstream stalled: 4 accepted, 5th and 6th dropped
    tick(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0);
      if (i == 3) begin
        check("fill_level4", level, 4);
        check("fill_no_ovf", overflow, 0);
      end
      if (i == 4) check("fill_ovf_set", overflow, 1);
    end
    check("full_level", level, 4);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    check("drained_level", level, 0);
    check("ovf_sticky", overflow, 1);

    // Run until five wraps, then leave three entries queued
    for (int i = 0; i < 200 && exp_wc < 5; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    check("pre_rst_level", level, 3);
    check("pre_rst_wrap_cnt", wrap_cnt, 5);

    // Asynchronous reset mid-cycle clears everything immediately
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_level", level, 0);
    check("arst_overflow", overflow, 0);
    check("arst_wrap_pulse", wrap_pulse, 0);
    check("arst_wrap_cnt", wrap_cnt, 0);
    check("arst_seq_err", seq_err, 0);
    model_reset();
    cnt      = 4'h0;
    count_in = 4'h0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1'b0, 1'b1);
    check("post_rst_no_wrap", wrap_pulse, 0);
    check("post_rst_no_seq", seq_err, 0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    check("full2_level", level, 4);
    tick(1'b1, 1'b1);
    check("full_pushpop_level", level, 4);
    check("full_pushpop_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    check("empty_level", level, 0);
    check("empty_out_valid", out_valid, 0);
    check("empty_out_data", out_data, 0);

    // Single entry with simultaneous push and pop
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check("one_pushpop_level", level, 1);
    tick(1'b0, 1'b1);
    check("one_drained_level", level, 0);

    // Sequence jump 3 -> 7
    for (int i = 0; i < 16 && cnt != 4'd3; i++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    drive(4'd7, 1'b0, 1'b1);
    cnt = 4'd8;
`ifdef COUNT_SAMPLER_SEQCHK_EN
    check("seq_jump_set", seq_err, 1);
`else
    check("seq_jump_off", seq_err, 0);
`endif
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
`ifdef COUNT_SAMPLER_SEQCHK_EN
    check("seq_sticky", seq_err, 1);
`else
    check("seq_stays_off", seq_err, 0);
`endif

    // Wrap counter saturation
    for (int i = 0; i < 260 * 16; i++) tick(1'b0, 1'b1);
    check("wrap_cnt_sat", wrap_cnt, 255);

    tick(1'b0, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
